// File: rtl/frm_rx_pkg.sv
// Shared constants, frame FSM encoding and a width helper for the 485 uplink receiver.
package frm_rx_pkg;

   localparam logic [7:0] SYNC0 = 8'hEB;
   localparam logic [7:0] SYNC1 = 8'h90;

   typedef enum logic [2:0] {
      HUNT1 = 3'd0,
      HUNT2 = 3'd1,
      ID    = 3'd2,
      LEN   = 3'd3,
      PAY   = 3'd4,
      SUM   = 3'd5
   } frm_state_e;

   function automatic int clog2(input int val);
      int r;
      r = 0;
      while ((1 << r) < val) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/frm_rx_485_uart_rx_byte.sv
// UART byte deserialiser: 2-FF synchroniser, mid-bit sampling every CLK_DIV cycles, LSB first.
// byte_vld / fr_err are 1-cycle strobes one cycle after the stop sample, mutually exclusive.
module uart_rx_byte
   import frm_rx_pkg::*;
#(
   parameter int CLK_DIV = 100
) (
   input  logic       clk_sys,
   input  logic       rst,
   input  logic       rx_a,
   output logic [7:0] rx_byte,
   output logic       byte_vld,
   output logic       fr_err
);

   localparam int CW = clog2(CLK_DIV);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);

   logic          rx_s1_q, rx_s2_q, rx_s3_q;
   logic          busy_q, busy_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    byte_q, byte_d;
   logic          vld_q, vld_d;
   logic          ferr_q, ferr_d;

   // Synchroniser resets to idle-high so reset release never looks like a start edge.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         byte_q  <= '0;
         vld_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         rx_s1_q <= rx_a;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         byte_q  <= byte_d;
         vld_q   <= vld_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
      if (!busy_q) begin
         if (rx_s3_q && !rx_s2_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            bit_d  = '0;
         end
      end else if (cnt_q != ((bit_q == 4'd0) ? HALF_M1 : FULL_M1)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
         bit_d = bit_q + 4'd1;
         if (bit_q == 4'd0) begin
            // start bit high again at mid-bit: a glitch, go back to idle
            if (rx_s2_q) busy_d = 1'b0;
         end else if (bit_q == 4'd9) begin
            busy_d = 1'b0;
            byte_d = shift_q;
            vld_d  = rx_s2_q;
            ferr_d = !rx_s2_q;
         end else begin
            shift_d = {rx_s2_q, shift_q[7:1]};
         end
      end
   end

   assign rx_byte  = byte_q;
   assign byte_vld = vld_q;
   assign fr_err   = ferr_q;

endmodule

// File: rtl/frm_rx_485.sv
// Master-side 485 uplink frame receiver: sync hunt, header/length/checksum check, payload stream.
// Optional good/bad frame counters are built when FRM_RX_STAT_EN is defined.
module frm_rx_485
   import frm_rx_pkg::*;
#(
   parameter int CLK_DIV = 100,
   parameter int MAX_LEN = 200,
   parameter int TO_BITS = 20
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        rx_a,
   output logic [7:0]  dev_id,
   output logic [7:0]  frm_data,
   output logic        frm_vld,
   output logic        frm_sop,
   output logic        frm_done,
   output logic        frm_err,
   output logic [15:0] frm_cnt,
   output logic [15:0] err_cnt
);

   localparam int TO_LIM = TO_BITS * CLK_DIV;
   localparam int TW     = clog2(TO_LIM);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_LIM - 1);

   logic [7:0]    rx_byte;
   logic          byte_vld, fr_err;
   frm_state_e    state_q, state_d;
   logic [7:0]    dev_id_q, dev_id_d, len_q, len_d, idx_q, idx_d, sum_q, sum_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          in_frame, strobe, to_exp, len_bad, abort;

   uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .rx_a     (rx_a),
      .rx_byte  (rx_byte),
      .byte_vld (byte_vld),
      .fr_err   (fr_err)
   );

   assign in_frame = (state_q != HUNT1) && (state_q != HUNT2);
   assign strobe   = byte_vld | fr_err;
   // A byte strobe on the expiry cycle wins over the timeout.
   assign to_exp   = in_frame && !strobe && (to_cnt_q == TO_LAST);
   assign len_bad  = (rx_byte == 8'd0) || (int'(rx_byte) > MAX_LEN);
   assign abort    = in_frame && (fr_err || to_exp);

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT1;
         dev_id_q <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         sum_q    <= '0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         dev_id_q <= dev_id_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         sum_q    <= sum_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = HUNT1;
      end else if (byte_vld) begin
         case (state_q)
            HUNT1:   if (rx_byte == SYNC0) state_d = HUNT2;
            HUNT2: begin
               if (rx_byte == SYNC1)      state_d = ID;
               else if (rx_byte != SYNC0) state_d = HUNT1;
            end
            ID:      state_d = LEN;
            LEN:     state_d = len_bad ? HUNT1 : PAY;
            PAY:     if (idx_q + 8'd1 == len_q) state_d = SUM;
            SUM:     state_d = HUNT1;
            default: state_d = HUNT1;
         endcase
      end
   end

   always_comb begin
      dev_id_d = dev_id_q;
      len_d    = len_q;
      idx_d    = idx_q;
      sum_d    = sum_q;
      to_cnt_d = (in_frame && !strobe) ? to_cnt_q + 1'b1 : '0;
      if (byte_vld) begin
         case (state_q)
            ID: begin
               dev_id_d = rx_byte;
               sum_d    = rx_byte;
            end
            LEN: begin
               len_d = rx_byte;
               idx_d = '0;
               sum_d = sum_q + rx_byte;
            end
            PAY: begin
               idx_d = idx_q + 8'd1;
               sum_d = sum_q + rx_byte;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      frm_vld  = byte_vld && (state_q == PAY);
      frm_sop  = frm_vld && (idx_q == 8'd0);
      frm_done = abort || (byte_vld && (((state_q == LEN) && len_bad) || (state_q == SUM)));
      frm_err  = abort || (byte_vld && (state_q == LEN) && len_bad)
                       || (byte_vld && (state_q == SUM) && (rx_byte != sum_q));
   end

   assign frm_data = rx_byte;
   assign dev_id   = dev_id_q;

`ifdef FRM_RX_STAT_EN
   logic [15:0] frm_cnt_q, frm_cnt_d, err_cnt_q, err_cnt_d;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         frm_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         frm_cnt_q <= frm_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_comb begin
      frm_cnt_d = frm_cnt_q;
      err_cnt_d = err_cnt_q;
      if (frm_done && !frm_err && (frm_cnt_q != 16'hFFFF)) frm_cnt_d = frm_cnt_q + 16'd1;
      if (frm_done && frm_err && (err_cnt_q != 16'hFFFF))  err_cnt_d = err_cnt_q + 16'd1;
   end

   assign frm_cnt = frm_cnt_q;
   assign err_cnt = err_cnt_q;
`else
   assign frm_cnt = 16'h0;
   assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_frm_rx_485.sv
// Self-checking bench for frm_rx_485: byte-stream segments are scored by a frame-level model
// that predicts the ordered payload/done events; one process compares every DUT event.
`timescale 1ns/1ps
module tb_frm_rx_485;

   localparam int CLK_DIV  = 8;
   localparam int MAX_LEN  = 200;
   localparam int TO_BITS  = 20;
   localparam int LONG_GAP = 16;

   logic        clk_sys = 1'b0;
   logic        rst;
   logic        rx_a;
   logic [7:0]  dev_id, frm_data;
   logic        frm_vld, frm_sop, frm_done, frm_err;
   logic [15:0] frm_cnt, err_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic [10:0] exp_q[$];
   logic [7:0]  seg_b[$];
   bit          seg_ok[$];
   int          seg_gap[$];
   logic [7:0]  m_dev;
   int          m_good, m_bad;

   frm_rx_485 #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN), .TO_BITS(TO_BITS)) dut (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .rx_a     (rx_a),
      .dev_id   (dev_id),
      .frm_data (frm_data),
      .frm_vld  (frm_vld),
      .frm_sop  (frm_sop),
      .frm_done (frm_done),
      .frm_err  (frm_err),
      .frm_cnt  (frm_cnt),
      .err_cnt  (err_cnt)
   );

   // clock / watchdog
   always #5 clk_sys = ~clk_sys;

   initial begin
      #3ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // event word: {is_done, sop, err, data}
   function automatic logic [10:0] ev_pay(input logic [7:0] d, input bit sop);
      return {1'b0, sop, 1'b0, d};
   endfunction

   function automatic logic [10:0] ev_done(input bit err);
      return {1'b1, 1'b0, err, 8'h00};
   endfunction

`ifdef FRM_RX_STAT_EN
   function automatic int exp_stat(input int n);
      return (n > 65535) ? 65535 : n;
   endfunction
`else
   function automatic int exp_stat(input int n);
      return (n < 0) ? n : 0;
   endfunction
`endif

   // scoreboard compare: every payload / done strobe must match the next predicted event
   always @(negedge clk_sys) begin : cmp
      logic [10:0] got;
      if (!rst) begin
         if (frm_sop) check("sop_with_vld", frm_vld, 1'b1);
         if (frm_vld || frm_done) begin
            got = frm_done ? ev_done(frm_err) : ev_pay(frm_data, frm_sop);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_event got=%0h want=none", got);
            end else begin
               check("event", got, exp_q.pop_front());
            end
         end
      end
   end

   // driver tasks
   task automatic send_bit(input logic v);
      rx_a = v;
      repeat (CLK_DIV) @(posedge clk_sys);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_ok);
   endtask

   task automatic idle_bits(input int n);
      rx_a = 1'b1;
      repeat (n * CLK_DIV) @(posedge clk_sys);
   endtask

   task automatic seg_clear();
      seg_b.delete();
      seg_ok.delete();
      seg_gap.delete();
   endtask

   // gap = idle bit-times before this byte; a byte after a bad stop needs a high gap to re-edge
   task automatic seg_add(input logic [7:0] b, input bit ok, input int gap);
      int g;
      g = gap;
      if (seg_ok.size() > 0 && !seg_ok[seg_ok.size() - 1] && g == 0) g = 1;
      seg_b.push_back(b);
      seg_ok.push_back(ok);
      seg_gap.push_back(g);
   endtask

   task automatic add_rand(input logic [7:0] b);
      bit ok;
      int gap;
      ok  = ($urandom_range(0, 19) != 0);
      gap = ($urandom_range(0, 24) == 0) ? LONG_GAP : int'($urandom_range(0, 2));
      seg_add(b, ok, gap);
   endtask

   task automatic push_done(input bit err);
      exp_q.push_back(ev_done(err));
      if (err) m_bad++;
      else     m_good++;
   endtask

   // Frame-level model over a whole byte segment: search sync, then walk the fields.
   task automatic model_segment(input bit abort_end);
      int n, p, fld;
      bit ended;
      logic [7:0] b, len, sum, cnt;
      n = seg_b.size();
      p = 0;
      while (p < n) begin
         if (!seg_ok[p] || seg_b[p] != 8'hEB) begin
            p++;
         end else begin
            p++;
            while (p < n && (!seg_ok[p] || seg_b[p] == 8'hEB)) p++;
            if (p < n && seg_b[p] != 8'h90) begin
               p++;
            end else if (p < n) begin
               p++;
               fld = 0; ended = 0; len = 0; sum = 0; cnt = 0;
               while (!ended) begin
                  if (p >= n) begin
                     if (!abort_end) push_done(1'b1);
                     ended = 1;
                  end else if (seg_gap[p] >= LONG_GAP) begin
                     push_done(1'b1);
                     ended = 1;
                  end else if (!seg_ok[p]) begin
                     push_done(1'b1);
                     p++;
                     ended = 1;
                  end else begin
                     b = seg_b[p];
                     p++;
                     case (fld)
                        0: begin
                           m_dev = b;
                           sum   = b;
                           fld   = 1;
                        end
                        1: begin
                           len = b;
                           sum = sum + b;
                           if (b == 8'd0 || int'(b) > MAX_LEN) begin
                              push_done(1'b1);
                              ended = 1;
                           end else begin
                              fld = 2;
                           end
                        end
                        2: begin
                           exp_q.push_back(ev_pay(b, cnt == 8'd0));
                           sum = sum + b;
                           cnt = cnt + 8'd1;
                           if (cnt == len) fld = 3;
                        end
                        default: begin
                           push_done(b != sum);
                           ended = 1;
                        end
                     endcase
                  end
               end
            end
         end
      end
   endtask

   task automatic drive_segment();
      for (int k = 0; k < seg_b.size(); k++) begin
         idle_bits(seg_gap[k]);
         send_byte(seg_b[k], seg_ok[k]);
      end
      rx_a = 1'b1;
   endtask

   task automatic finish_segment();
      idle_bits(TO_BITS + 5);
      @(negedge clk_sys);
      check("events_left", exp_q.size(), 0);
      exp_q.delete();
      check("dev_id", dev_id, m_dev);
      check("frm_cnt", frm_cnt, exp_stat(m_good));
      check("err_cnt", err_cnt, exp_stat(m_bad));
   endtask

   task automatic add_list(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] b6, input int n);
      logic [7:0] v[7];
      v = '{b0, b1, b2, b3, b4, b5, b6};
      for (int i = 0; i < n; i++) seg_add(v[i], 1'b1, 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_dev_id"}, dev_id, 8'h00);
      check({tag, "_data"}, frm_data, 8'h00);
      check({tag, "_flags"}, {frm_vld, frm_sop, frm_done, frm_err}, 4'h0);
      check({tag, "_frm_cnt"}, frm_cnt, 16'h0);
      check({tag, "_err_cnt"}, err_cnt, 16'h0);
   endtask

   initial begin
      logic [7:0] id, len, sum, b;
      int r;
      rst = 1'b1; rx_a = 1'b1;
      m_dev = 8'h00; m_good = 0; m_bad = 0;
      repeat (4) @(posedge clk_sys);
      @(negedge clk_sys);
      check_outputs_zero("reset");
      @(posedge clk_sys);
      rst = 1'b0;
      idle_bits(2);

      // 1: good frame
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 7);
      seg_add(8'h6E, 1'b1, 0);
      model_segment(1'b0);
      check("pin1_size", exp_q.size(), 4);
      check("pin1_e0", exp_q[0], 11'h211);
      check("pin1_e1", exp_q[1], 11'h022);
      check("pin1_e2", exp_q[2], 11'h033);
      check("pin1_e3", exp_q[3], 11'h400);
      check("pin1_dev", m_dev, 8'h05);
      drive_segment();
      finish_segment();

      // 2: bad checksum
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 7);
      seg_add(8'h6F, 1'b1, 0);
      model_segment(1'b0);
      check("pin2_size", exp_q.size(), 4);
      check("pin2_e3", exp_q[3], 11'h500);
      drive_segment();
      finish_segment();

      // 3: noise before sync
      seg_clear();
      add_list(8'hEB, 8'hEB, 8'h90, 8'h01, 8'h01, 8'hAA, 8'hAC, 7);
      model_segment(1'b0);
      check("pin3_size", exp_q.size(), 2);
      check("pin3_e0", exp_q[0], 11'h2AA);
      check("pin3_e1", exp_q[1], 11'h400);
      drive_segment();
      finish_segment();

      // 4: length 0 and length 201
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h02, 8'h00, 8'hEB, 8'h90, 8'h02, 7);
      seg_add(8'hC9, 1'b1, 0);
      model_segment(1'b0);
      check("pin4_size", exp_q.size(), 2);
      check("pin4_e0", exp_q[0], 11'h500);
      check("pin4_e1", exp_q[1], 11'h500);
      drive_segment();
      finish_segment();

      // 4b: maximum length accepted
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h3C, 8'(MAX_LEN), 8'h00, 8'h00, 8'h00, 4);
      sum = 8'h3C + 8'(MAX_LEN);
      for (int i = 0; i < MAX_LEN; i++) begin
         b = 8'($urandom_range(0, 255));
         sum = sum + b;
         seg_add(b, 1'b1, 0);
      end
      seg_add(sum, 1'b1, 0);
      model_segment(1'b0);
      check("pin4b_size", exp_q.size(), MAX_LEN + 1);
      drive_segment();
      finish_segment();

      // 5: timeout mid-payload, then a good frame
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h03, 8'h04, 8'hB1, 8'hB2, 8'h00, 6);
      seg_add(8'hEB, 1'b1, 25);
      add_list(8'h90, 8'h03, 8'h01, 8'hC5, 8'hC9, 8'h00, 8'h00, 5);
      model_segment(1'b0);
      check("pin5_size", exp_q.size(), 5);
      check("pin5_e2", exp_q[2], 11'h500);
      check("pin5_e3", exp_q[3], 11'h2C5);
      check("pin5_e4", exp_q[4], 11'h400);
      drive_segment();
      finish_segment();

      // 6: framing error on a payload byte, then a good frame
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h04, 8'h03, 8'hD1, 8'h00, 8'h00, 5);
      seg_add(8'hD2, 1'b0, 0);
      add_list(8'hD3, 8'h7D, 8'hEB, 8'h90, 8'h04, 8'h01, 8'hE0, 7);
      seg_add(8'hE5, 1'b1, 0);
      model_segment(1'b0);
      check("pin6_size", exp_q.size(), 4);
      check("pin6_e1", exp_q[1], 11'h500);
      check("pin6_e3", exp_q[3], 11'h400);
      drive_segment();
      finish_segment();

      // 6b: reset mid-payload, then a good frame
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h07, 8'h04, 8'hA1, 8'hA2, 8'h00, 6);
      model_segment(1'b1);
      check("pin6b_size", exp_q.size(), 2);
      drive_segment();
      idle_bits(2);
      rst = 1'b1;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check_outputs_zero("midrst");
      check("midrst_events_left", exp_q.size(), 0);
      exp_q.delete();
      m_dev = 8'h00; m_good = 0; m_bad = 0;
      @(posedge clk_sys);
      rst = 1'b0;
      idle_bits(3);
      seg_clear();
      add_list(8'hEB, 8'h90, 8'h09, 8'h02, 8'h01, 8'h02, 8'h0E, 7);
      model_segment(1'b0);
      check("pin6b_e2", exp_q[2], 11'h400);
      drive_segment();
      finish_segment();

      // randomized frames with noise, bad lengths, bad sums, framing errors and long gaps
      for (int f = 0; f < 30; f++) begin
         seg_clear();
         r = $urandom_range(0, 2);
         for (int i = 0; i < r; i++) add_rand(8'($urandom_range(0, 255)));
         id = 8'($urandom_range(0, 255));
         r = $urandom_range(0, 9);
         if (r == 0) len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
         else        len = 8'($urandom_range(1, 10));
         add_rand(8'hEB);
         add_rand(8'h90);
         add_rand(id);
         add_rand(len);
         if (len != 8'h00 && int'(len) <= MAX_LEN) begin
            sum = id + len;
            for (int i = 0; i < int'(len); i++) begin
               b = 8'($urandom_range(0, 255));
               sum = sum + b;
               add_rand(b);
            end
            if ($urandom_range(0, 3) == 0) sum = sum ^ 8'(1 << $urandom_range(0, 7));
            add_rand(sum);
         end
         model_segment(1'b0);
         drive_segment();
         finish_segment();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
